// File: rtl/bram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter_pkg
// Purpose  : Shared constants for the BRAM port arbiter. This file holds the
//            sequencer state encodings and the requester identifiers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bram_port_arbiter_pkg;

    // Sequencer states
    localparam logic [0:0] ST_CLEAR = 1'b0;  // zero-filling the BRAM, no requester served
    localparam logic [0:0] ST_RUN   = 1'b1;  // normal arbitration

    // Requester identifiers, also used as the round-robin pointer value
    localparam logic [0:0] REQ0 = 1'b0;
    localparam logic [0:0] REQ1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bram_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin arbiter. A lone requester is granted at once.
//            On contention the requester named by the priority pointer wins.
//            After any grant the pointer moves to the requester that was not
//            granted, so a stalled loser always wins on the next cycle.
// Ports    : clock   in  1  clock, state on posedge
//            reset   in  1  synchronous active-high, pointer -> REQ0
//            i_req   in  2  request vector, bit n = requester n
//            o_grant out 2  one-hot grant, combinational
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import bram_port_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

    logic r_ptr;  // requester favoured when both ask

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_ptr == REQ1) ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= REQ0;
        end else if (o_grant[0]) begin
            r_ptr <= REQ1;
        end else if (o_grant[1]) begin
            r_ptr <= REQ0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_port_arbiter
// Purpose  : Shares one simple-dual-port BRAM (1 read port with registered
//            read data, 1 write port) between two requesters. The read and
//            write ports are arbitrated independently by round-robin. An
//            optional post-reset sequencer zero-fills the BRAM before any
//            requester is served.
// Ports    : clock, reset              clock / synchronous active-high reset
//            reqN_read/readAddress     read request + address (N = 0,1)
//            reqN_read_ready           read granted this cycle
//            reqN_readValid/readData   read result, one cycle after grant
//            reqN_write/writeAddress/writeData  write request
//            reqN_write_ready          write granted this cycle
//            bram_*                    all BRAM port signals
// Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0_read,
    input  logic [ADDR_WIDTH-1:0] req0_readAddress,
    output logic                  req0_read_ready,
    output logic                  req0_readValid,
    output logic [DATA_WIDTH-1:0] req0_readData,
    input  logic                  req0_write,
    input  logic [ADDR_WIDTH-1:0] req0_writeAddress,
    input  logic [DATA_WIDTH-1:0] req0_writeData,
    output logic                  req0_write_ready,

    input  logic                  req1_read,
    input  logic [ADDR_WIDTH-1:0] req1_readAddress,
    output logic                  req1_read_ready,
    output logic                  req1_readValid,
    output logic [DATA_WIDTH-1:0] req1_readData,
    input  logic                  req1_write,
    input  logic [ADDR_WIDTH-1:0] req1_writeAddress,
    input  logic [DATA_WIDTH-1:0] req1_writeData,
    output logic                  req1_write_ready,

    output logic                  bram_readEnable,
    output logic [ADDR_WIDTH-1:0] bram_readAddress,
    input  logic [DATA_WIDTH-1:0] bram_readData,
    output logic                  bram_writeEnable,
    output logic [ADDR_WIDTH-1:0] bram_writeAddress,
    output logic [DATA_WIDTH-1:0] bram_writeData
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = '1;

    logic [0:0]            r_state;
    logic [0:0]            w_nextState;
    logic [ADDR_WIDTH-1:0] r_clrCnt;
    logic [1:0]            r_rdOwner;   // one-hot owner of the read in flight
    logic                  w_serve;
    logic [1:0]            w_rdReq;
    logic [1:0]            w_wrReq;
    logic [1:0]            w_rdGrant;
    logic [1:0]            w_wrGrant;

    // Requests are hidden from the arbiters while clearing or in reset, so
    // nobody is granted and the priority pointers stay put.
    assign w_serve = (r_state == ST_RUN) && !reset;
    assign w_rdReq = w_serve ? {req1_read,  req0_read}  : 2'b00;
    assign w_wrReq = w_serve ? {req1_write, req0_write} : 2'b00;

    rr_arbiter2 u_rdArb (
        .clock   (clock),
        .reset   (reset),
        .i_req   (w_rdReq),
        .o_grant (w_rdGrant)
    );

    rr_arbiter2 u_wrArb (
        .clock   (clock),
        .reset   (reset),
        .i_req   (w_wrReq),
        .o_grant (w_wrGrant)
    );

    assign req0_read_ready  = w_rdGrant[0];
    assign req1_read_ready  = w_rdGrant[1];
    assign req0_write_ready = w_wrGrant[0];
    assign req1_write_ready = w_wrGrant[1];

    // Masking with reset drops a read granted in the cycle just before reset.
    assign req0_readValid = r_rdOwner[0] && !reset;
    assign req1_readValid = r_rdOwner[1] && !reset;
    assign req0_readData  = bram_readData;
    assign req1_readData  = bram_readData;

    // Next state and BRAM port muxes
    always_comb begin
        w_nextState       = r_state;
        bram_readEnable   = |w_rdGrant;
        bram_readAddress  = w_rdGrant[1] ? req1_readAddress : req0_readAddress;
        bram_writeEnable  = |w_wrGrant;
        bram_writeAddress = w_wrGrant[1] ? req1_writeAddress : req0_writeAddress;
        bram_writeData    = w_wrGrant[1] ? req1_writeData    : req0_writeData;

        if (r_state == ST_CLEAR) begin
            bram_writeEnable  = 1'b1;
            bram_writeAddress = r_clrCnt;
            bram_writeData    = '0;
            if (r_clrCnt == C_LAST_ADDR) begin
                w_nextState = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clrCnt  <= '0;
            r_rdOwner <= 2'b00;
        end else begin
            r_state   <= w_nextState;
            r_rdOwner <= w_rdGrant;
            if (r_state == ST_CLEAR) begin
                r_clrCnt <= r_clrCnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_port_arbiter
// Purpose  : Self-checking bench. Instance A (AW=4, clear on reset) covers the
//            zero-fill sequencer; instance B (AW=8, no clear) covers the
//            arbitration. Each instance drives a behavioural BRAM with
//            registered, write-first read data. Expected read results are
//            queued at grant time and checked when readValid appears.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int nVec = 0;
    int nErr = 0;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t eA, eB;

    // ---------------- instance A: AW=4, clear on reset ----------------
    logic        a_reset;
    logic        a_r0, a_r1, a_w0, a_w1;
    logic [3:0]  a_ra0, a_ra1, a_wa0, a_wa1;
    logic [31:0] a_wd0, a_wd1;
    logic        a_rrdy0, a_rrdy1, a_wrdy0, a_wrdy1, a_val0, a_val1;
    logic [31:0] a_d0, a_d1;
    logic        a_re, a_we;
    logic [3:0]  a_ra, a_wa;
    logic [31:0] a_rd, a_wd;
    logic [31:0] a_mem [16];

    bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) u_dutA (
        .clock(clock), .reset(a_reset),
        .req0_read(a_r0), .req0_readAddress(a_ra0), .req0_read_ready(a_rrdy0),
        .req0_readValid(a_val0), .req0_readData(a_d0),
        .req0_write(a_w0), .req0_writeAddress(a_wa0), .req0_writeData(a_wd0), .req0_write_ready(a_wrdy0),
        .req1_read(a_r1), .req1_readAddress(a_ra1), .req1_read_ready(a_rrdy1),
        .req1_readValid(a_val1), .req1_readData(a_d1),
        .req1_write(a_w1), .req1_writeAddress(a_wa1), .req1_writeData(a_wd1), .req1_write_ready(a_wrdy1),
        .bram_readEnable(a_re), .bram_readAddress(a_ra), .bram_readData(a_rd),
        .bram_writeEnable(a_we), .bram_writeAddress(a_wa), .bram_writeData(a_wd)
    );

    always @(posedge clock) begin
        if (a_we) a_mem[a_wa] <= a_wd;
        if (a_re) a_rd <= (a_we && (a_wa == a_ra)) ? a_wd : a_mem[a_ra];
    end

    // ---------------- instance B: AW=8, serve immediately ----------------
    logic        b_reset;
    logic        b_r0, b_r1, b_w0, b_w1;
    logic [7:0]  b_ra0, b_ra1, b_wa0, b_wa1;
    logic [31:0] b_wd0, b_wd1;
    logic        b_rrdy0, b_rrdy1, b_wrdy0, b_wrdy1, b_val0, b_val1;
    logic [31:0] b_d0, b_d1;
    logic        b_re, b_we;
    logic [7:0]  b_ra, b_wa;
    logic [31:0] b_rd, b_wd;
    logic [31:0] b_mem [256];

    bram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .CLEAR_ON_RESET(1'b0)) u_dutB (
        .clock(clock), .reset(b_reset),
        .req0_read(b_r0), .req0_readAddress(b_ra0), .req0_read_ready(b_rrdy0),
        .req0_readValid(b_val0), .req0_readData(b_d0),
        .req0_write(b_w0), .req0_writeAddress(b_wa0), .req0_writeData(b_wd0), .req0_write_ready(b_wrdy0),
        .req1_read(b_r1), .req1_readAddress(b_ra1), .req1_read_ready(b_rrdy1),
        .req1_readValid(b_val1), .req1_readData(b_d1),
        .req1_write(b_w1), .req1_writeAddress(b_wa1), .req1_writeData(b_wd1), .req1_write_ready(b_wrdy1),
        .bram_readEnable(b_re), .bram_readAddress(b_ra), .bram_readData(b_rd),
        .bram_writeEnable(b_we), .bram_writeAddress(b_wa), .bram_writeData(b_wd)
    );

    always @(posedge clock) begin
        if (b_we) b_mem[b_wa] <= b_wd;
        if (b_re) b_rd <= (b_we && (b_wa == b_ra)) ? b_wd : b_mem[b_ra];
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a readValid is seen.
    always begin
        @(negedge clock);
        #2;
        if (a_val0 || a_val1) begin
            chk("A single valid", {a_val1, a_val0} == 2'b11, 1'b0);
            if (qA.size() == 0) begin
                chk("A unexpected valid", {a_val1, a_val0}, 2'b00);
            end else begin
                eA = qA.pop_front();
                chk("A valid owner", a_val1, eA.owner);
                chk("A read data", a_val1 ? a_d1 : a_d0, eA.data);
            end
        end
        if (b_val0 || b_val1) begin
            chk("B single valid", {b_val1, b_val0} == 2'b11, 1'b0);
            if (qB.size() == 0) begin
                chk("B unexpected valid", {b_val1, b_val0}, 2'b00);
            end else begin
                eB = qB.pop_front();
                chk("B valid owner", b_val1, eB.owner);
                chk("B read data", b_val1 ? b_d1 : b_d0, eB.data);
            end
        end
    end

    // One cycle on B: inputs are already driven; check ready vector
    // {wr1, wr0, rd1, rd0}, queue expected read result, advance.
    task automatic cycB(input string nm, input logic [3:0] expRdy, input logic [31:0] rdExp, input bit push);
        #1;
        chk(nm, {60'h0, b_wrdy1, b_wrdy0, b_rrdy1, b_rrdy0}, {60'h0, expRdy});
        if (push && expRdy[0]) qB.push_back({1'b0, rdExp});
        if (push && expRdy[1]) qB.push_back({1'b1, rdExp});
        @(negedge clock);
    endtask

    // One clearing cycle on A with the expected sweep address.
    task automatic clrA(input logic [3:0] addr);
        #1;
        chk("A clear port", {25'h0, a_we, a_wa, a_wd, a_rrdy0, a_re},
            {25'h0, 1'b1, addr, 32'h0, 1'b0, 1'b0});
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) a_mem[i] = 32'hA5A5_0000 + i;
        for (int i = 0; i < 256; i++) b_mem[i] = 32'h0;
        a_reset = 1'b1; b_reset = 1'b1;
        {a_r0, a_r1, a_w0, a_w1} = '0;
        {b_r0, b_r1, b_w0, b_w1} = '0;
        a_ra0 = 4'h3; a_ra1 = '0; a_wa0 = '0; a_wa1 = '0; a_wd0 = '0; a_wd1 = '0;
        b_ra0 = '0; b_ra1 = '0; b_wa0 = '0; b_wa1 = '0; b_wd0 = '0; b_wd1 = '0;

        @(negedge clock);

        // ---------- A: full clear then first read ----------
        a_r0 = 1'b1;
        #1; chk("A reset ready", a_rrdy0, 1'b0);
        @(negedge clock);
        a_reset = 1'b0;
        for (int i = 0; i < 16; i++) clrA(4'(i));
        #1;
        chk("A run grant", {a_rrdy0, a_we, a_ra}, {1'b1, 1'b0, 4'h3});
        qA.push_back({1'b0, 32'h0});
        @(negedge clock);
        a_r0 = 1'b0;
        @(negedge clock);

        // ---------- A: reset at clr_cnt==7 restarts the sweep ----------
        a_reset = 1'b1;
        @(negedge clock);
        a_reset = 1'b0;
        for (int i = 0; i < 7; i++) clrA(4'(i));
        a_reset = 1'b1;
        @(negedge clock);
        a_reset = 1'b0;
        a_r0 = 1'b1;
        for (int i = 0; i < 16; i++) clrA(4'(i));
        #1;
        chk("A run grant again", a_rrdy0, 1'b1);
        qA.push_back({1'b0, 32'h0});
        @(negedge clock);
        a_r0 = 1'b0;
        @(negedge clock);

        // ---------- B: reset state ----------
        b_r0 = 1'b1; b_w1 = 1'b1;
        cycB("B reset ready", 4'b0000, 32'h0, 1'b0);
        cycB("B reset ready", 4'b0000, 32'h0, 1'b0);
        b_reset = 1'b0; b_r0 = 1'b0; b_w1 = 1'b0;

        // preload through the write port, single requester each time
        b_w0 = 1'b1; b_wa0 = 8'h05; b_wd0 = 32'hDEAD_BEEF;
        cycB("B wr 05", 4'b0100, 32'h0, 1'b0);
        b_w0 = 1'b0; b_w1 = 1'b1; b_wa1 = 8'h01; b_wd1 = 32'h0101_0101;
        cycB("B wr 01", 4'b1000, 32'h0, 1'b0);
        b_w1 = 1'b0; b_w0 = 1'b1; b_wa0 = 8'h02; b_wd0 = 32'h0202_0202;
        cycB("B wr 02", 4'b0100, 32'h0, 1'b0);
        b_w0 = 1'b0;

        // lone reads from each requester
        b_r0 = 1'b1; b_ra0 = 8'h05;
        cycB("B rd0 05", 4'b0001, 32'hDEAD_BEEF, 1'b1);
        b_r0 = 1'b0;
        cycB("B idle", 4'b0000, 32'h0, 1'b0);
        b_r1 = 1'b1; b_ra1 = 8'h05;
        cycB("B rd1 05", 4'b0010, 32'hDEAD_BEEF, 1'b1);
        b_r1 = 1'b0;
        cycB("B idle", 4'b0000, 32'h0, 1'b0);

        // fresh reset so both pointers favour requester 0
        b_reset = 1'b1;
        cycB("B reset ready", 4'b0000, 32'h0, 1'b0);
        b_reset = 1'b0;

        // continuous read contention alternates starting with req0
        b_r0 = 1'b1; b_ra0 = 8'h01; b_r1 = 1'b1; b_ra1 = 8'h02;
        cycB("B rr g0", 4'b0001, 32'h0101_0101, 1'b1);
        cycB("B rr g1", 4'b0010, 32'h0202_0202, 1'b1);
        cycB("B rr g0", 4'b0001, 32'h0101_0101, 1'b1);
        cycB("B rr g1", 4'b0010, 32'h0202_0202, 1'b1);
        b_r0 = 1'b0; b_r1 = 1'b0;
        cycB("B idle", 4'b0000, 32'h0, 1'b0);

        // write contention on one address, loser lands last
        b_w0 = 1'b1; b_wa0 = 8'h10; b_wd0 = 32'h1111;
        b_w1 = 1'b1; b_wa1 = 8'h10; b_wd1 = 32'h2222;
        cycB("B ww g0", 4'b0100, 32'h0, 1'b0);
        b_w0 = 1'b0;
        cycB("B ww g1", 4'b1000, 32'h0, 1'b0);
        b_w1 = 1'b0; b_r0 = 1'b1; b_ra0 = 8'h10;
        cycB("B rd 10", 4'b0001, 32'h2222, 1'b1);
        b_r0 = 1'b0;
        cycB("B idle", 4'b0000, 32'h0, 1'b0);

        // same-cycle read and write of one address returns new data
        b_r0 = 1'b1; b_ra0 = 8'h20; b_w1 = 1'b1; b_wa1 = 8'h20; b_wd1 = 32'hCAFE;
        cycB("B rd+wr 20", 4'b1001, 32'hCAFE, 1'b1);
        b_r0 = 1'b0; b_w1 = 1'b0;
        cycB("B idle", 4'b0000, 32'h0, 1'b0);

        // read granted, reset next cycle: no valid may appear
        b_r1 = 1'b1; b_ra1 = 8'h01;
        cycB("B rd before reset", 4'b0010, 32'h0, 1'b0);
        b_r1 = 1'b0; b_reset = 1'b1;
        #2;
        chk("B valid under reset", {b_val1, b_val0}, 2'b00);
        cycB("B reset ready", 4'b0000, 32'h0, 1'b0);
        b_reset = 1'b0;
        cycB("B idle", 4'b0000, 32'h0, 1'b0);
        cycB("B idle", 4'b0000, 32'h0, 1'b0);

        chk("A queue drained", 64'(qA.size()), 64'h0);
        chk("B queue drained", 64'(qB.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
